// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if -- request/result bundle for alu_pipe.
//
// Request side : in_valid/in_ready handshake, operands a/b, mode, opsel.
// Result side  : out_valid/out_ready handshake, result, carry, err.
// Optional     : zero, neg, ovf status flags exist only when the macro
//                ALU_PIPE_STATUS_FLAGS_EN is defined.
//
// Modports
//   master : the requester/consumer (drives operands and out_ready).
//   slave  : the ALU itself (drives in_ready and the registered outputs).
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic [2:0]       opsel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             err;
`ifdef ALU_PIPE_STATUS_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, mode, opsel, out_ready,
    input  in_ready, out_valid, result, carry, err
`ifdef ALU_PIPE_STATUS_FLAGS_EN
    , input zero, neg, ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, mode, opsel, out_ready,
    output in_ready, out_valid, result, carry, err
`ifdef ALU_PIPE_STATUS_FLAGS_EN
    , output zero, neg, ovf
`endif
  );
endinterface

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- single-stage registered ALU with valid/ready on both sides.
//
// An accepted request ({mode,opsel}, a, b) produces result/err one clock
// later with out_valid set. The output register stalls while the consumer
// withholds out_ready; in_ready = !out_valid || out_ready, so a consume and
// a new accept can happen in the same cycle (one op per cycle).
//
// A carry flag C is kept across operations: arithmetic codes load it with
// the carry-out, shift-left loads it with the shifted-out bit, all other
// codes leave it alone. Subtract-with-borrow (0001) consumes the old C,
// which lets consecutive ops chain for multi-word subtraction.
//
// Ports
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset; clears out_valid/result/err/C.
//   bus   : alu_pipe_if.slave (see interface file for the signal list).
//
// Configuration
//   ALU_PIPE_STATUS_FLAGS_EN : adds registered zero/neg/ovf outputs.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SBC  = 4'b0001,
    OP_MOV  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_INC  = 4'b0100,
    OP_DEC  = 4'b0101,
    OP_ADD1 = 4'b0110,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_XOR  = 4'b1010,
    OP_NOT  = 4'b1011,
    OP_SHL  = 4'b1101
  } op_e;

  // Registered state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             err_q,       err_d;
  logic             carry_q,     carry_d;

  // Datapath
  logic [3:0]       code;
  logic             accept;
  logic             arith;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             c_upd;
  logic             c_new;

  assign code   = {bus.mode, bus.opsel};
  assign accept = bus.in_valid && bus.in_ready;

  // Every arithmetic code is one adder pass A + op2 + cin at WIDTH+1 bits:
  // subtraction feeds ~B, decrement adds all-ones (so C=1 means no borrow,
  // as for the other subtractions).
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    arith   = 1'b0;
    op2     = '0;
    cin     = 1'b0;
    alu_res = '0;
    alu_err = 1'b0;
    c_upd   = 1'b0;
    c_new   = carry_q;

    case (code)
      OP_ADD:  begin arith = 1'b1; op2 = bus.b;                 end
      OP_SBC:  begin arith = 1'b1; op2 = ~bus.b; cin = carry_q; end
      OP_SUB:  begin arith = 1'b1; op2 = ~bus.b; cin = 1'b1;    end
      OP_INC:  begin arith = 1'b1;               cin = 1'b1;    end
      OP_DEC:  begin arith = 1'b1; op2 = '1;                    end
      OP_ADD1: begin arith = 1'b1; op2 = bus.b;  cin = 1'b1;    end
      OP_MOV:  alu_res = bus.a;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOT:  alu_res = ~bus.a;
      OP_SHL:  begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        c_upd   = 1'b1;
        c_new   = bus.a[WIDTH-1];
      end
      default: alu_err = 1'b1;
    endcase

    sum = {1'b0, bus.a} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      alu_res = sum[WIDTH-1:0];
      c_upd   = 1'b1;
      c_new   = sum[WIDTH];
    end
  end

  // Output register: load on accept, drop valid on a bare consume, else hold.
  always_comb begin
    out_valid_d = accept || (out_valid_q && !bus.out_ready);
    result_d    = accept ? alu_res : result_q;
    err_d       = accept ? alu_err : err_q;
    carry_d     = (accept && c_upd) ? c_new : carry_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      carry_q     <= carry_d;
    end
  end

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.carry     = carry_q;

`ifdef ALU_PIPE_STATUS_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q,  neg_d;
  logic ovf_q,  ovf_d;
  logic ovf_new;

  // Signed overflow: both adder inputs share a sign and the sum's sign differs.
  assign ovf_new = arith && (bus.a[WIDTH-1] == op2[WIDTH-1])
                         && (sum[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    zero_d = accept ? (alu_res == '0)      : zero_q;
    neg_d  = accept ? alu_res[WIDTH-1]     : neg_q;
    ovf_d  = accept ? ovf_new              : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;
`else
  // Status flags disabled: no zero/neg/ovf state or ports.
`endif

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be legal for any value >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 a, b  input  WIDTH each  operands A and B.
REQ-007 mode  input  1  0 = arithmetic group, 1 = logic/shift group.
REQ-008 opsel  input  3  operation select within group.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  WIDTH  registered operation result.
REQ-012 carry  output  1  current stored carry flag C.
REQ-013 err  output  1  registered with result; 1 when {mode,opsel} was an illegal code.

Function
REQ-014 Handshake SHALL be: request accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready, combinationally; no request is ever dropped or duplicated.
REQ-016 Latency SHALL be 1 cycle: an accepted request appears on result/err with out_valid=1 on the next rising edge.
REQ-017 While out_valid && !out_ready, result, err and out_valid SHALL hold unchanged.
REQ-018 Simultaneous consume and accept SHALL load the new result with out_valid remaining 1 (full throughput, one op per cycle).
REQ-019 Consume with no accept SHALL clear out_valid; result holds its last value.
REQ-020 Codes {mode,opsel}: 0000 A+B; 0001 A+~B+C (subtract with borrow, C=1 means no borrow); 0010 A; 0011 A-B; 0100 A+1; 0101 A-1; 0110 A+B+1; 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1101 A<<1, LSB filled with 0.
REQ-021 All other codes SHALL give result 0 and err=1; legal codes give err=0.
REQ-022 All arithmetic SHALL be modulo 2^WIDTH, computed at WIDTH+1 bits; bit WIDTH is the carry-out.
REQ-023 Subtraction SHALL be computed as A+~B+1, so C=1 after 0011 means no borrow.
REQ-024 C SHALL update on acceptance only, for codes 0000, 0001, 0011, 0100, 0101 and 0110 (to the carry-out), and for 1101 (to the old A[WIDTH-1]).
REQ-025 Logic codes, move and illegal codes SHALL leave C unchanged.
REQ-026 Code 0001 SHALL use C as it was before the accepting edge; back-to-back 0001 ops SHALL chain correctly for multi-word subtraction.

Reset
REQ-027 While rst_n=0: out_valid=0, result=0, err=0, C=0, independent of clk.
REQ-028 A result pending at reset assertion SHALL be discarded.
REQ-029 in_ready SHALL read 1 during and after reset.
REQ-030 The first request SHALL be acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro ALU_PIPE_STATUS_FLAGS_EN defined: extra outputs zero, neg and ovf (1 bit each), registered with result and held under stall.
REQ-032 zero = (result==0); neg = result[WIDTH-1]; ovf = signed overflow, for codes 0000, 0001, 0011, 0100, 0101 and 0110 only.
REQ-033 ovf SHALL be 0 for all other codes, and all three flags SHALL reset to 0.
REQ-034 Macro undefined: the three ports SHALL NOT exist and their logic SHALL NOT be present; all other behaviour is identical.

Verification
REQ-035 WIDTH=8, in: 0000 a=0xF0 b=0x20, out_ready=1 -> next cycle: result=0x10, carry=1, out_valid=1, err=0.
REQ-036 WIDTH=8, in: 0011 a=0x00 b=0x01 -> result=0xFF, carry=0; then 0001 a=0x01 b=0x00 -> result=0x00, carry=1.
REQ-037 out_ready=0 for 3 cycles after op 1010 a=0x0F b=0xFF -> result holds 0xF0 and in_ready=0; second request held until out_ready=1, then it completes in the next cycle.
REQ-038 In: code 0111 -> result=0, err=1, carry unchanged; then code 1101 a=0x81 -> result=0x02, carry=1.
REQ-039 rst_n pulled low mid-stall with out_valid=1 -> out_valid, result and carry go to 0 immediately (asynchronously); after release, a streaming run of 16 back-to-back ops with out_ready=1 gives 16 results in order.
REQ-040 With ALU_PIPE_STATUS_FLAGS_EN defined: 0000 a=0x7F b=0x01 -> result=0x80, neg=1, ovf=1, zero=0.
